// File: rtl/sample_playback.sv
//------------------------------------------------------------------------------
// Module  : sample_playback
// Brief   : Record-then-replay sample buffer with valid/ready playback output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_playback #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               rec_start,
    input  logic               play_start,
    input  logic               stop,
    input  logic               loop,
    input  logic [D_WIDTH-1:0] mic_signal,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_sample,
    output logic               out_valid,
    output logic [A_WIDTH:0]   rec_len,
    output logic               busy
);

    localparam int             c_DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] c_FULL = (A_WIDTH + 1)'(c_DEPTH);
    localparam logic [A_WIDTH:0] c_ONE  = (A_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_PLAY   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t             r_state;
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [A_WIDTH-1:0] r_rd_ptr;
    logic [A_WIDTH-1:0] r_fetch_addr;
    logic               r_fetch;
    logic [A_WIDTH:0]   r_rec_len;
    logic [D_WIDTH-1:0] r_out_sample;
    logic               r_out_valid;
    logic [D_WIDTH-1:0] r_mem [c_DEPTH];

    logic               w_wr;
    logic               w_issue;
    logic               w_last;
    logic [A_WIDTH:0]   w_rec_next;

    assign w_wr       = !rst && (r_state == S_RECORD) && en && !stop;
    // Issue only when the output slot will be free next cycle and nothing is in flight.
    assign w_issue    = (r_state == S_PLAY) && !stop && !r_fetch &&
                        (!r_out_valid || out_ready);
    assign w_last     = (({1'b0, r_rd_ptr} + c_ONE) == r_rec_len);
    assign w_rec_next = r_rec_len + c_ONE;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= mic_signal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fetch_addr <= '0;
            r_fetch      <= 1'b0;
            r_rec_len    <= '0;
            r_out_sample <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            if (r_fetch) begin
                r_out_sample <= r_mem[r_fetch_addr];
                r_out_valid  <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid  <= 1'b0;
            end
            r_fetch <= w_issue;
            if (w_issue) begin
                r_fetch_addr <= r_rd_ptr;
            end

            case (r_state)
                S_IDLE: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (rec_start) begin
                        r_state   <= S_RECORD;
                        r_wr_ptr  <= '0;
                        r_rec_len <= '0;
                    end else if (play_start && (r_rec_len != '0)) begin
                        r_state  <= S_PLAY;
                        r_rd_ptr <= '0;
                    end
                end
                S_RECORD: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (en) begin
                        r_wr_ptr  <= r_wr_ptr + 1'b1;
                        r_rec_len <= w_rec_next;
                        if (w_rec_next == c_FULL) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_fetch     <= 1'b0;
                    end else if (w_issue) begin
                        if (w_last && loop) begin
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                            if (w_last) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (stop) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_fetch     <= 1'b0;
                    end else if (r_out_valid && out_ready && !r_fetch) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_sample = r_out_sample;
    assign out_valid  = r_out_valid;
    assign rec_len    = r_rec_len;
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sample_playback.sv
//------------------------------------------------------------------------------
// Module  : tb_sample_playback
// Brief   : Directed self-checking bench for sample_playback (A_WIDTH=4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sample_playback;

    localparam int A_WIDTH = 4;
    localparam int D_WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               rec_start;
    logic               play_start;
    logic               stop;
    logic               loop;
    logic [D_WIDTH-1:0] mic_signal;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_sample;
    logic               out_valid;
    logic [A_WIDTH:0]   rec_len;
    logic               busy;

    int                 n_vec = 0;
    int                 n_err = 0;
    int                 got;
    logic [D_WIDTH-1:0] got_buf [64];

    sample_playback #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .loop       (loop),
        .mic_signal (mic_signal),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .rec_len    (rec_len),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Collects accepted samples; out_ready is dropped for cycles [stall_lo, stall_hi).
    task automatic collect(input int want, input int budget, input int stall_lo, input int stall_hi);
        logic [D_WIDTH-1:0] held;
        logic               held_v;
        held   = '0;
        held_v = 1'b0;
        got    = 0;
        for (int c = 0; c < budget && got < want; c++) begin
            out_ready = !(c >= stall_lo && c < stall_hi);
            if (!out_ready && out_valid) begin
                if (held_v) chk("hold_sample", out_sample, held);
                held   = out_sample;
                held_v = 1'b1;
            end
            if (out_valid && out_ready) begin
                got_buf[got] = out_sample;
                got++;
            end
            step();
        end
        out_ready = 1'b1;
        chk("collect_count", got, want);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rec_start = 1'b0; play_start = 1'b0;
        stop = 1'b0; loop = 1'b0; mic_signal = '0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_len", rec_len, 0);
        chk("rst_sample", out_sample, 0);

        // play with nothing recorded is ignored
        play_start = 1'b1; step(); play_start = 1'b0;
        chk("empty_play_busy", busy, 0);

        // record 10..50, then stop with en high: that sample must be dropped
        rec_start = 1'b1; step(); rec_start = 1'b0;
        chk("rec_busy", busy, 1);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mic_signal = 8'((i + 1) * 10);
            step();
        end
        mic_signal = 8'd99; stop = 1'b1; step();
        stop = 1'b0; en = 1'b0;
        chk("rec1_len", rec_len, 5);
        chk("rec1_busy", busy, 0);

        // straight playback
        play_start = 1'b1; step(); play_start = 1'b0;
        collect(5, 60, 1000, 1000);
        for (int i = 0; i < 5; i++) chk("play1_data", got_buf[i], (i + 1) * 10);
        chk("play1_valid_end", out_valid, 0);
        chk("play1_busy_end", busy, 0);

        // playback with back-pressure mid-stream
        play_start = 1'b1; step(); play_start = 1'b0;
        collect(5, 80, 5, 11);
        for (int i = 0; i < 5; i++) chk("play2_data", got_buf[i], (i + 1) * 10);
        chk("play2_busy_end", busy, 0);

        // looping playback of 1,2,3
        rec_start = 1'b1; step(); rec_start = 1'b0;
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            mic_signal = 8'(i);
            step();
        end
        en = 1'b0; stop = 1'b1; step(); stop = 1'b0;
        chk("rec3_len", rec_len, 3);
        loop = 1'b1;
        play_start = 1'b1; step(); play_start = 1'b0;
        collect(9, 80, 1000, 1000);
        for (int i = 0; i < 9; i++) chk("loop_data", got_buf[i], (i % 3) + 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("loop_stop_valid", out_valid, 0);
        chk("loop_stop_busy", busy, 0);
        loop = 1'b0;

        // overfill: 20 strobes into a 16-deep buffer
        rec_start = 1'b1; step(); rec_start = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mic_signal = 8'(100 + i);
            step();
            if (i == 15) begin
                chk("full_len_at16", rec_len, 16);
                chk("full_auto_idle", busy, 0);
            end
        end
        en = 1'b0;
        chk("full_len_final", rec_len, 16);
        play_start = 1'b1; step(); play_start = 1'b0;
        collect(16, 120, 1000, 1000);
        chk("full_first", got_buf[0], 100);
        chk("full_last", got_buf[15], 115);
        chk("full_busy_end", busy, 0);

        // rec_start beats play_start; then reset during playback
        rec_start = 1'b1; play_start = 1'b1; step();
        rec_start = 1'b0; play_start = 1'b0;
        chk("prio_busy", busy, 1);
        chk("prio_len_cleared", rec_len, 0);
        en = 1'b1;
        mic_signal = 8'd7; step();
        mic_signal = 8'd8; step();
        en = 1'b0; stop = 1'b1; step(); stop = 1'b0;
        chk("rec6_len", rec_len, 2);
        out_ready = 1'b0;
        play_start = 1'b1; step(); play_start = 1'b0;
        step(); step();
        chk("rst_mid_valid_before", out_valid, 1);
        chk("rst_mid_sample_before", out_sample, 7);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_len", rec_len, 0);
        chk("rst_mid_busy", busy, 0);
        out_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
